// File: rtl/ring_sampler_pkg.sv
// Shared types and constants for the ring oscillator sampler.
package ring_sampler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDrain,
    StHold
  } state_e;

  // The enable drops one synchroniser depth plus the edge-detect stage before the
  // last ring edge can reach the counter.
  function automatic int unsigned drain_cycles(input int unsigned sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/ring_sampler_if.sv
// Result port of the ring sampler: valid/ready handshake carrying count, snapshot and saturation.
interface ring_sampler_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
);

  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic [N-1:0]     res_snap;
  logic             res_sat;

  modport master (
    output res_valid,
    input  res_ready,
    output res_count,
    output res_snap,
    output res_sat
  );

  modport slave (
    input  res_valid,
    output res_ready,
    input  res_count,
    input  res_snap,
    input  res_sat
  );

endinterface

// File: rtl/ring_sampler_sync_bus.sv
// W-wide multi-flop synchroniser with synchronous active-high reset.
module sync_bus #(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/ring_sampler.sv
// Gates a self-timed ring for a programmed window, counts its handshake transitions and
// returns the count plus a tap snapshot through a valid/ready result port.
module ring_sampler
  import ring_sampler_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  output logic             ring_en,
  input  logic             ack_in,
  input  logic [N-1:0]     taps_in,
  output logic             busy,
  ring_sampler_if.master   res
);

  localparam int unsigned      D         = drain_cycles(SYNC_STAGES);
  localparam logic [WIN_W-1:0] DrainLoad = WIN_W'(D - 1);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  logic [N:0]       sync_out;
  logic             ack_s;
  logic [N-1:0]     taps_s;
  logic             prev_ack_q;
  logic             ack_edge;
  logic             counting;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [N-1:0]     snap_q, snap_d;
  logic             ring_en_q;

  sync_bus #(
    .W      (N + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({ack_in, taps_in}),
    .q   (sync_out)
  );

  assign ack_s    = sync_out[N];
  assign taps_s   = sync_out[N-1:0];
  assign ack_edge = ack_s ^ prev_ack_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    count_d  = count_q;
    sat_d    = sat_q;
    snap_d   = snap_q;
    counting = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d = '0;
          sat_d   = 1'b0;
          if (window != '0) begin
            state_d = StCount;
            timer_d = window - 1'b1;
          end else begin
            state_d = StDrain;
            timer_d = DrainLoad;
          end
        end
      end
      StCount: begin
        counting = 1'b1;
        if (timer_q == '0) begin
          state_d = StDrain;
          timer_d = DrainLoad;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StDrain: begin
        counting = 1'b1;
        if (timer_q == '0) begin
          snap_d  = taps_s;
          state_d = StHold;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StHold: begin
        if (res.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clearing on start and counting are in different states, so they never collide.
    if (counting && ack_edge) begin
      if (count_q == CntMax) sat_d = 1'b1;
      else                   count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      snap_q     <= '0;
      prev_ack_q <= 1'b0;
      ring_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      snap_q     <= snap_d;
      prev_ack_q <= ack_s;
      ring_en_q  <= (state_d == StCount);
    end
  end

  assign ring_en       = ring_en_q;
  assign busy          = (state_q != StIdle);
  assign res.res_valid = (state_q == StHold);
  assign res.res_count = count_q;
  assign res.res_snap  = snap_q;
  assign res.res_sat   = sat_q;

endmodule

// File: tb/tb_ring_sampler.sv
// Bench for ring_sampler: a 16-bit-counter instance and a 3-bit-counter instance share stimulus.
module tb_ring_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] window;
  logic        ack;
  logic [31:0] taps;
  logic        ready;
  logic        ring_en_a, ring_en_b, busy_a, busy_b;

  int n_pass  = 0;
  int n_total = 0;

  ring_sampler_if #(.N(32), .CNT_W(16)) res_a ();
  ring_sampler_if #(.N(32), .CNT_W(3))  res_b ();

  assign res_a.res_ready = ready;
  assign res_b.res_ready = ready;

  ring_sampler #(.N(32), .SYNC_STAGES(2), .WIN_W(16), .CNT_W(16)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .window  (window),
    .ring_en (ring_en_a),
    .ack_in  (ack),
    .taps_in (taps),
    .busy    (busy_a),
    .res     (res_a)
  );

  ring_sampler #(.N(32), .SYNC_STAGES(2), .WIN_W(16), .CNT_W(3)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .window  (window),
    .ring_en (ring_en_b),
    .ack_in  (ack),
    .taps_in (taps),
    .busy    (busy_b),
    .res     (res_b)
  );

  always #5 clk = ~clk;

  // mode: 0 = ack constant, 1 = toggle every 2nd enabled cycle, 2 = toggle every enabled cycle
  typedef struct {
    logic [15:0] window;
    int          mode;
    logic [31:0] taps;
    int          cnt_a;
    int          sat_a;
    int          cnt_b;
    int          sat_b;
    int          lat;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Starts a run, drives ack while the ring is enabled, then checks the result on res_valid.
  task automatic launch(input vec_t v);
    vec_t e;
    int   en_cnt = 0;
    int   phase  = 0;
    int   lat    = 0;
    bit   got    = 0;
    sb.push_back(v);
    window = v.window;
    taps   = v.taps;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int c = 1; c <= 300 && !got; c++) begin
      if (res_a.res_valid) begin
        got = 1;
        lat = c;
      end else begin
        if (ring_en_a) begin
          en_cnt++;
          phase++;
          if (v.mode == 2 || (v.mode == 1 && (phase % 2) == 0)) ack = ~ack;
        end
        step();
      end
    end
    chk("res_valid_seen", longint'(got), 1);
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("ring_en_cycles", en_cnt, longint'(e.window));
    chk("busy_in_hold", busy_a, 1);
    chk("ring_en_in_hold", ring_en_a, 0);
    chk("count_a", res_a.res_count, e.cnt_a);
    chk("sat_a", res_a.res_sat, e.sat_a);
    chk("snap_a", res_a.res_snap, e.taps);
    chk("valid_b", res_b.res_valid, 1);
    chk("count_b", res_b.res_count, e.cnt_b);
    chk("sat_b", res_b.res_sat, e.sat_b);
    chk("snap_b", res_b.res_snap, e.taps);
  endtask

  task automatic accept();
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("valid_after_accept", res_a.res_valid, 0);
    chk("busy_after_accept", busy_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t hv;
    logic [15:0] cnt_hold;
    vecs[0] = '{16'd10, 0, 32'hA5A5_0F0F, 0,  0, 0, 0, 14};
    vecs[1] = '{16'd16, 1, 32'h1234_5678, 8,  0, 7, 1, 20};
    vecs[2] = '{16'd20, 2, 32'hDEAD_BEEF, 20, 0, 7, 1, 24};
    vecs[3] = '{16'd0,  0, 32'hFFFF_0000, 0,  0, 0, 0, 4};
    vecs[4] = '{16'd1,  2, 32'h0000_0001, 1,  0, 1, 0, 5};
    vecs[5] = '{16'd3,  1, 32'h8000_0000, 1,  0, 1, 0, 7};

    rst = 1'b1; start = 1'b0; window = '0; ack = 1'b0; taps = '0; ready = 1'b0;
    repeat (3) step();
    chk("rst_ring_en", ring_en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", res_a.res_valid, 0);
    chk("rst_count", res_a.res_count, 0);
    chk("rst_snap", res_a.res_snap, 0);
    chk("rst_sat", res_a.res_sat, 0);
    rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i]);
      accept();
      repeat (2) step();
    end

    // HOLD stall: outputs stable with ready low, start ignored, then start coinciding with accept
    hv = '{16'd2, 0, 32'h0F0F_F0F0, 0, 0, 0, 0, 6};
    launch(hv);
    cnt_hold = res_a.res_count;
    for (int i = 0; i < 5; i++) begin
      taps   = ~taps;
      start  = (i == 2);
      window = 16'd5;
      step();
      chk("hold_valid", res_a.res_valid, 1);
      chk("hold_busy", busy_a, 1);
      chk("hold_ring_en", ring_en_a, 0);
      chk("hold_count", res_a.res_count, cnt_hold);
      chk("hold_snap", res_a.res_snap, 32'h0F0F_F0F0);
    end
    start = 1'b1;
    ready = 1'b1;
    step();
    start = 1'b0;
    ready = 1'b0;
    chk("accept_with_start_valid", res_a.res_valid, 0);
    chk("accept_with_start_busy", busy_a, 0);
    step();
    chk("no_queued_run_busy", busy_a, 0);
    chk("no_queued_run_ring_en", ring_en_a, 0);
    chk("result_kept_in_idle", res_a.res_snap, 32'h0F0F_F0F0);

    // Reset in the middle of COUNT
    window = 16'd16;
    taps   = 32'h3C3C_C3C3;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int c = 1; c < 5; c++) begin
      ack = ~ack;
      step();
    end
    chk("pre_reset_count", res_a.res_count, 2);
    chk("pre_reset_ring_en", ring_en_a, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ring_en", ring_en_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_valid", res_a.res_valid, 0);
    chk("mid_rst_count", res_a.res_count, 0);
    chk("mid_rst_snap", res_a.res_snap, 0);
    repeat (4) step();
    hv = '{16'd10, 1, 32'h5555_AAAA, 5, 0, 5, 0, 14};
    launch(hv);
    accept();

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ring_sampler.md
Name: ring_sampler

Overview:
- Synchronous consumer that sits directly downstream of the self-timed ring stage on the Fomu fabric.
- Gates the ring via its enable input (intext[0] side) for a programmed number of clock cycles.
- Synchronises the ring's handshake bit and its N tap outputs into the clock domain, and counts handshake transitions over the window.
- Returns count plus a tap snapshot through a valid/ready result port.

Parameters:
N, 32, width of ring tap bus (matches ring stage depth)
SYNC_STAGES, 2, flops per synchroniser chain (min 2)
WIN_W, 16, width of window length input
CNT_W, 16, width of edge counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  request a measurement (sampled only in IDLE)
window  input  WIN_W  measurement length in clk cycles, latched on accepted start
ring_en  output  1  enable to ring stage (drives its intext[0])
ack_in  input  1  async handshake bit from ring stage (outtext[0])
taps_in  input  N  async tap bus from ring stage (outtext[cs +: N])
busy  output  1  high in any state except IDLE
res_valid  output  1  result valid
res_ready  input  1  consumer accepts result
res_count  output  CNT_W  handshake transitions counted
res_snap  output  N  synchronised tap snapshot
res_sat  output  1  counter saturated

Behaviour:
- Reset: all of the following are 0, FSM in IDLE:
  - outputs: ring_en, busy, res_valid, res_count, res_snap, res_sat
  - internal: all synchroniser flops, edge-detect register, timer, counter
- Synchronisers:
  - ack_in and each taps_in bit pass through SYNC_STAGES flops.
  - The tap bus is not coherent across bits; snapshot bits may be mutually skewed by one sample, which is acceptable.
- Edge detect:
  - prev_ack is updated every cycle in every state.
  - edge = ack_s ^ prev_ack, so both rising and falling edges count.
  - No spurious edge is generated on state entry.
- FSM states IDLE, COUNT, DRAIN, HOLD:
  - IDLE: start=1 at cycle t latches window and clears counter/sat.
    - window!=0: enter COUNT at t+1. ring_en is registered, high from t+1.
    - window==0: enter DRAIN at t+1; ring_en never asserts.
  - COUNT: ring_en=1; timer decrements each cycle.
    - Exactly `window` cycles in COUNT (t+1..t+window), then DRAIN.
  - DRAIN: ring_en=0 for D=SYNC_STAGES+1 cycles; edges are still counted, so in-flight edges are captured.
    - On the last DRAIN cycle, res_snap is loaded from the synchronised taps. HOLD is entered next cycle.
  - HOLD: res_valid=1; res_count, res_snap and res_sat are stable.
    - On res_valid&res_ready, go to IDLE; res_valid=0 next cycle.
- Counting:
  - counter increments on edge in COUNT and DRAIN only.
  - Saturates at 2^CNT_W-1; res_sat is set sticky when an edge arrives at max.
- Latency: start at t -> res_valid first high at t+window+D+1 (window=10, SYNC_STAGES=2 -> t+14).
- start outside IDLE is ignored, including the same cycle as the HOLD handshake; no queueing.
- res_ready outside HOLD has no effect.
- rst in any state: next cycle everything is at reset values, ring_en=0, partial result discarded.
- Result outputs keep their last values in IDLE until the next start clears the count. res_valid is the only qualifier.

Decomposition:
- Package ring_sampler_pkg:
  - state enum (IDLE, COUNT, DRAIN, HOLD)
  - localparam/function for D = SYNC_STAGES+1
- Sub-module sync_bus #(W, STAGES): W-wide multi-flop synchroniser with synchronous reset. Instantiate once for {ack_in, taps_in} (W=N+1).
- Top module holds FSM, timer, counter, edge detect and result registers.

Test Plan:
- Bench holds ack_in constant, taps_in=32'hA5A5_0F0F; window=10, start at t -> ring_en high t+1..t+10, res_valid at t+14, res_count=0, res_sat=0, res_snap=32'hA5A5_0F0F.
- window=16; bench toggles ack_in every 2 cycles only while ring_en=1 -> res_count=8, res_sat=0.
- CNT_W=3, window=20, ack_in toggles every cycle while ring_en=1 -> res_count=7, res_sat=1.
- res_ready low for 5 cycles in HOLD, with start pulsed meanwhile -> outputs stable, busy=1, no new run. res_ready=1 -> res_valid=0 next cycle, IDLE.
- window=0, start at t -> ring_en never high, res_valid at t+4, res_count=0.
- rst asserted mid-COUNT (cycle t+5 of window=16) -> next cycle ring_en=0, busy=0, res_valid=0, counter=0. A new start then runs normally.
